// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS main control FSM sequencing fetch/decode/execute/memory/write-back
module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] OpALU,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECUTE = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010;
  state_t cs, ns;
  logic [5:0] op_q;
  always_ff @(posedge clk)
    if (reset) begin
      cs <= FETCH;
      op_q <= '0;
    end else begin
      cs <= ns;
      if (cs == DECODE) op_q <= opcode;
    end
  always_comb begin
    ns = FETCH;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst} = '0;
    PCSource = 2'b00;
    ALUSrcB = 2'b00;
    OpALU = 2'b00;
    illegal_op = 1'b0;
    state = reset ? 4'd0 : cs;
    case (cs)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        ns = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ns = (opcode == OP_LW || opcode == OP_SW) ? MEMADDR :
             opcode == OP_R ? EXECUTE : opcode == OP_BEQ ? BRANCH :
             opcode == OP_J ? JUMP : FETCH;
        illegal_op = ns == FETCH;
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ns = op_q == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        ns = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        ns = RWB;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        ns = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        OpALU = 2'b10;
        ns = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        OpALU = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
      end
      default: ns = FETCH;
    endcase
    if (reset) begin
      {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst} = '0;
      PCSource = 2'b00;
      ALUSrcB = 2'b00;
      OpALU = 2'b00;
      illegal_op = 1'b0;
    end
  end
endmodule
